// File: rtl/iv_seq_ctrl.sv
// iv_seq_ctrl: interrupt entry / return sequencer.
//   Handles hardware IRQ entry, SVC traps (with a priority check), return-from-interrupt and
//   tail-chaining, using its own single-port memory handshake for vector fetches and stack
//   pushes/pops.
// Ports:
//   clk, rst_n                     clock (rising edge), async active-low reset
//   start_enter, start_return      start pulses (return wins when both are high)
//   svc_inst, svc_vect             SVC qualifier and vector number
//   irq, irq_pri                   level requests and per-source priorities
//   pc_in..sp_in                   current CPU state
//   mem_req/we/addr/wdata          memory request, held until mem_ack
//   mem_ack, mem_rdata             memory completion and read data
//   *_ld, *_out                    one-cycle register load strobes and values
//   irq_ack                        one-hot pulse of the source entered
//   pri_fault                      SVC rejected for priority (pulses with done)
//   busy, done                     sequence in progress / completion pulse
module iv_seq_ctrl #(
    parameter int unsigned    DW        = 16,
    parameter int unsigned    PRI_W     = 3,
    parameter int unsigned    NUM_SRC   = 8,
    parameter logic [DW-1:0]  VECT_BASE = 16'hFFC0,
    parameter int unsigned    CUR_LSB   = 5,
    parameter int unsigned    PREV_LSB  = 13,
    parameter int unsigned    SLP_BIT   = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_enter,
    input  logic                     start_return,
    input  logic                     svc_inst,
    input  logic [3:0]               svc_vect,
    input  logic [NUM_SRC-1:0]       irq,
    input  logic [NUM_SRC*PRI_W-1:0] irq_pri,
    input  logic [DW-1:0]            pc_in,
    input  logic [DW-1:0]            lr_in,
    input  logic [DW-1:0]            psw_in,
    input  logic [DW-1:0]            cex_in,
    input  logic [DW-1:0]            sp_in,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [DW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ack,
    input  logic [DW-1:0]            mem_rdata,
    output logic                     pc_ld,
    output logic                     lr_ld,
    output logic                     psw_ld,
    output logic                     cex_ld,
    output logic                     sp_ld,
    output logic [DW-1:0]            pc_out,
    output logic [DW-1:0]            lr_out,
    output logic [DW-1:0]            psw_out,
    output logic [DW-1:0]            cex_out,
    output logic [DW-1:0]            sp_out,
    output logic [NUM_SRC-1:0]       irq_ack,
    output logic                     pri_fault,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned VW = ($clog2(NUM_SRC) > 4) ? $clog2(NUM_SRC) : 4;

    typedef enum logic [3:0] {
        StIdle, StFetchPsw, StPushPc, StPushLr, StPushPsw, StPushCex, StLoadPsw,
        StFetchEntry, StPopCex, StPopPsw, StPopLr, StPopPc, StFinish
    } state_e;

    state_e             state_q, state_d;
    logic [DW-1:0]      sp_q, psw_q, vpsw_q;
    logic [VW-1:0]      vect_q;
    logic [PRI_W-1:0]   base_q;
    logic               svc_q, chain_q, fault_q;

    // Arbitration: highest priority wins; strict compare keeps the lowest index on ties.
    logic               win_valid;
    logic [VW-1:0]      win_idx;
    logic [PRI_W-1:0]   win_pri;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        win_pri   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (irq[i] && (!win_valid || irq_pri[i*PRI_W +: PRI_W] > win_pri)) begin
                win_valid = 1'b1;
                win_idx   = VW'(i);
                win_pri   = irq_pri[i*PRI_W +: PRI_W];
            end
        end
    end

    logic chain_ok, enter_ok, svc_fault;
    logic [DW-1:0] vaddr;

    assign chain_ok  = win_valid && (win_pri > psw_in[PREV_LSB +: PRI_W]);
    assign enter_ok  = start_enter && (svc_inst || win_valid);
    assign svc_fault = svc_q && (mem_rdata[CUR_LSB +: PRI_W] < psw_q[CUR_LSB +: PRI_W]);
    assign vaddr     = VECT_BASE + (DW'(vect_q) << 2);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_return) begin
                    state_d = chain_ok ? StFetchPsw : StPopCex;
                end else if (enter_ok) begin
                    state_d = StFetchPsw;
                end
            end
            StFetchPsw: begin
                if (mem_ack) begin
                    if (svc_fault)    state_d = StFinish;
                    else if (chain_q) state_d = StLoadPsw;
                    else              state_d = StPushPc;
                end
            end
            StPushPc:     if (mem_ack) state_d = StPushLr;
            StPushLr:     if (mem_ack) state_d = StPushPsw;
            StPushPsw:    if (mem_ack) state_d = StPushCex;
            StPushCex:    if (mem_ack) state_d = StLoadPsw;
            StLoadPsw:    state_d = StFetchEntry;
            StFetchEntry: if (mem_ack) state_d = StFinish;
            StPopCex:     if (mem_ack) state_d = StPopPsw;
            StPopPsw:     if (mem_ack) state_d = StPopLr;
            StPopLr:      if (mem_ack) state_d = StPopPc;
            StPopPc:      if (mem_ack) state_d = StFinish;
            StFinish:     state_d = StIdle;
            default:      state_d = StIdle;
        endcase
    end

    // Sequencer datapath: latched context, working SP and fetched vector PSW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q    <= '0;
            psw_q   <= '0;
            vpsw_q  <= '0;
            vect_q  <= '0;
            base_q  <= '0;
            svc_q   <= 1'b0;
            chain_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_return) begin
                        sp_q    <= sp_in;
                        psw_q   <= psw_in;
                        svc_q   <= 1'b0;
                        fault_q <= 1'b0;
                        chain_q <= chain_ok;
                        if (chain_ok) begin
                            // Chained handler inherits the interrupted level, not the current one.
                            vect_q <= win_idx;
                            base_q <= psw_in[PREV_LSB +: PRI_W];
                        end
                    end else if (enter_ok) begin
                        sp_q    <= sp_in;
                        psw_q   <= psw_in;
                        svc_q   <= svc_inst;
                        vect_q  <= svc_inst ? VW'(svc_vect) : win_idx;
                        base_q  <= psw_in[CUR_LSB +: PRI_W];
                        chain_q <= 1'b0;
                        fault_q <= 1'b0;
                    end
                end
                StFetchPsw: begin
                    if (mem_ack) begin
                        vpsw_q  <= mem_rdata;
                        fault_q <= svc_fault;
                    end
                end
                StPushPc, StPushLr, StPushPsw, StPushCex: begin
                    if (mem_ack) sp_q <= sp_q - DW'(2);
                end
                StPopCex, StPopPsw, StPopLr, StPopPc: begin
                    if (mem_ack) sp_q <= sp_q + DW'(2);
                end
                default: ;
            endcase
        end
    end

    // Output decode.
    logic [DW-1:0] psw_mod;

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_ld     = 1'b0;
        lr_ld     = 1'b0;
        psw_ld    = 1'b0;
        cex_ld    = 1'b0;
        sp_ld     = 1'b0;
        pc_out    = '0;
        lr_out    = '0;
        psw_out   = '0;
        cex_out   = '0;
        sp_out    = '0;
        irq_ack   = '0;
        pri_fault = 1'b0;
        done      = 1'b0;
        busy      = (state_q != StIdle);
        psw_mod   = '0;
        unique case (state_q)
            StFetchPsw: begin
                mem_req  = 1'b1;
                mem_addr = vaddr;
            end
            StPushPc, StPushLr, StPushPsw, StPushCex: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = sp_q;
                unique case (state_q)
                    StPushPc:  mem_wdata = pc_in;
                    StPushLr:  mem_wdata = lr_in;
                    StPushPsw: mem_wdata = psw_q;
                    default:   mem_wdata = cex_in;
                endcase
            end
            StLoadPsw: begin
                psw_mod                       = vpsw_q;
                psw_mod[PREV_LSB +: PRI_W]    = base_q;
                psw_mod[SLP_BIT]              = 1'b0;
                psw_ld                        = 1'b1;
                psw_out                       = psw_mod;
                sp_ld                         = 1'b1;
                sp_out                        = sp_q;
            end
            StFetchEntry: begin
                mem_req  = 1'b1;
                mem_addr = vaddr + DW'(2);
                pc_ld    = mem_ack;
                pc_out   = mem_rdata;
                lr_ld    = mem_ack;
                lr_out   = '1;
                cex_ld   = mem_ack;
                cex_out  = '0;
                if (mem_ack && !svc_q) irq_ack = NUM_SRC'(1) << vect_q;
            end
            StPopCex, StPopPsw, StPopLr, StPopPc: begin
                mem_req  = 1'b1;
                mem_addr = sp_q + DW'(2);
                unique case (state_q)
                    StPopCex: begin
                        cex_ld  = mem_ack;
                        cex_out = mem_rdata;
                    end
                    StPopPsw: begin
                        psw_mod          = mem_rdata;
                        psw_mod[SLP_BIT] = 1'b0;
                        psw_ld           = mem_ack;
                        psw_out          = psw_mod;
                    end
                    StPopLr: begin
                        lr_ld  = mem_ack;
                        lr_out = mem_rdata;
                    end
                    default: begin
                        pc_ld  = mem_ack;
                        pc_out = mem_rdata;
                        sp_ld  = mem_ack;
                        sp_out = sp_q + DW'(2);
                    end
                endcase
            end
            StFinish: begin
                done      = 1'b1;
                pri_fault = fault_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iv_seq_ctrl.sv
// Directed bench for iv_seq_ctrl with a behavioural memory (programmable ack delay) and a
// negedge monitor that logs writes, load strobes, irq_ack and pri_fault pulses.
module tb_iv_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_enter, start_return, svc_inst;
    logic [3:0]  svc_vect;
    logic [7:0]  irq;
    logic [23:0] irq_pri;
    logic [15:0] pc_in, lr_in, psw_in, cex_in, sp_in;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        pc_ld, lr_ld, psw_ld, cex_ld, sp_ld;
    logic [15:0] pc_out, lr_out, psw_out, cex_out, sp_out;
    logic [7:0]  irq_ack;
    logic        pri_fault, busy, done;

    always #5 clk = ~clk;

    iv_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start_enter(start_enter), .start_return(start_return),
        .svc_inst(svc_inst), .svc_vect(svc_vect), .irq(irq), .irq_pri(irq_pri),
        .pc_in(pc_in), .lr_in(lr_in), .psw_in(psw_in), .cex_in(cex_in), .sp_in(sp_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pc_ld(pc_ld), .lr_ld(lr_ld), .psw_ld(psw_ld), .cex_ld(cex_ld), .sp_ld(sp_ld),
        .pc_out(pc_out), .lr_out(lr_out), .psw_out(psw_out), .cex_out(cex_out),
        .sp_out(sp_out), .irq_ack(irq_ack), .pri_fault(pri_fault), .busy(busy), .done(done)
    );

    // Memory model; preloads go through pl_* so only this block writes the array.
    logic [15:0] mem [0:32767];
    int          ack_dly = 0;
    int          wcnt = 0;
    logic        pl_we = 1'b0;
    logic [15:0] pl_a = '0, pl_d = '0;

    assign mem_ack   = mem_req && (wcnt == ack_dly);
    assign mem_rdata = mem[mem_addr[15:1]];

    always @(posedge clk) begin
        if (pl_we) mem[pl_a[15:1]] <= pl_d;
        else if (mem_req && mem_ack && mem_we) mem[mem_addr[15:1]] <= mem_wdata;
        if (!mem_req || mem_ack) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    // Monitor: cumulative counters plus last captured values.
    int          n_wr = 0, n_ld = 0, n_ack = 0, n_fault = 0;
    logic [15:0] wr_a [0:63];
    logic [15:0] wr_d [0:63];
    logic [15:0] c_pc, c_lr, c_psw, c_cex, c_sp;
    logic [7:0]  c_ack;

    always @(negedge clk) begin
        if (mem_req && mem_ack && mem_we) begin
            wr_a[n_wr[5:0]] <= mem_addr;
            wr_d[n_wr[5:0]] <= mem_wdata;
            n_wr <= n_wr + 1;
        end
        n_ld <= n_ld + int'(pc_ld) + int'(lr_ld) + int'(psw_ld) + int'(cex_ld) + int'(sp_ld);
        if (pc_ld)  c_pc  <= pc_out;
        if (lr_ld)  c_lr  <= lr_out;
        if (psw_ld) c_psw <= psw_out;
        if (cex_ld) c_cex <= cex_out;
        if (sp_ld)  c_sp  <= sp_out;
        if (irq_ack != 8'h00) begin
            c_ack <= irq_ack;
            n_ack <= n_ack + 1;
        end
        if (pri_fault) n_fault <= n_fault + 1;
    end

    int n_checks = 0, n_errors = 0;
    int b_wr, b_ld, b_ack, b_fault;
    int lat;
    logic busy_first;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic snap();
        b_wr    = n_wr;
        b_ld    = n_ld;
        b_ack   = n_ack;
        b_fault = n_fault;
    endtask

    // Pulse a start; lat = cycles from the start pulse to done (bounded).
    task automatic run(input logic ret, input logic svc, input logic [3:0] sv, output int l);
        @(negedge clk);
        svc_inst = svc;
        svc_vect = sv;
        if (ret) start_return = 1'b1;
        else     start_enter  = 1'b1;
        @(posedge clk);
        #1;
        start_enter  = 1'b0;
        start_return = 1'b0;
        l = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            l++;
            if (k == 0) busy_first = busy;
            if (done) break;
        end
        #2;
    endtask

    task automatic check_writes(input string tag, input logic [15:0] sp, input logic [15:0] psw);
        check({tag, "_nwr"}, 32'(n_wr - b_wr), 32'd4);
        check({tag, "_wa0"}, 32'(wr_a[b_wr[5:0]]), 32'(sp));
        check({tag, "_wd0"}, 32'(wr_d[b_wr[5:0]]), 32'h1234);
        check({tag, "_wa1"}, 32'(wr_a[6'(b_wr + 1)]), 32'(sp - 16'd2));
        check({tag, "_wd1"}, 32'(wr_d[6'(b_wr + 1)]), 32'h5678);
        check({tag, "_wa2"}, 32'(wr_a[6'(b_wr + 2)]), 32'(sp - 16'd4));
        check({tag, "_wd2"}, 32'(wr_d[6'(b_wr + 2)]), 32'(psw));
        check({tag, "_wa3"}, 32'(wr_a[6'(b_wr + 3)]), 32'(sp - 16'd6));
        check({tag, "_wd3"}, 32'(wr_d[6'(b_wr + 3)]), 32'h9ABC);
    endtask

    initial begin
        rst_n = 1'b0;
        start_enter = 1'b0; start_return = 1'b0; svc_inst = 1'b0; svc_vect = '0;
        irq = '0; irq_pri = '0;
        pc_in = 16'h1234; lr_in = 16'h5678; cex_in = 16'h9ABC; psw_in = '0; sp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {28'd0, mem_req, busy, done, pri_fault}, 32'd0);
        check("rst_ld", {27'd0, pc_ld, lr_ld, psw_ld, cex_ld, sp_ld}, 32'd0);
        check("rst_addr", {16'd0, mem_addr}, 32'd0);
        rst_n = 1'b1;

        poke(16'hFFC8, 16'h00C8);   // vector 2: cur=6, SLP set
        poke(16'hFFCA, 16'h2000);
        poke(16'hFFC4, 16'h00C0);   // vector 1
        poke(16'hFFC6, 16'h2100);
        poke(16'hFFCC, 16'h0020);   // vector 3: cur=1
        poke(16'hFFD0, 16'h00A8);   // vector 4: cur=5, SLP set
        poke(16'hFFD2, 16'h3000);

        // T1: hw IRQ 2 entry.
        irq = 8'h04; irq_pri = '0; irq_pri[6 +: 3] = 3'd5;
        psw_in = 16'h0040; sp_in = 16'h0800;
        snap();
        run(1'b0, 1'b0, 4'd0, lat);
        check("t1_lat", 32'(lat), 32'd8);
        check("t1_busy", {31'd0, busy_first}, 32'd1);
        check_writes("t1", 16'h0800, 16'h0040);
        check("t1_sp", 32'(c_sp), 32'h07F8);
        check("t1_psw", 32'(c_psw), 32'h40C0);
        check("t1_pc", 32'(c_pc), 32'h2000);
        check("t1_lr", 32'(c_lr), 32'hFFFF);
        check("t1_cex", 32'(c_cex), 32'h0000);
        check("t1_ack", 32'(c_ack), 32'h04);
        check("t1_nld", 32'(n_ld - b_ld), 32'd5);

        // T2: tie between sources 1 and 5 -> lowest index.
        irq = 8'h22; irq_pri = '0; irq_pri[3 +: 3] = 3'd6; irq_pri[15 +: 3] = 3'd6;
        sp_in = 16'h0900;
        snap();
        run(1'b0, 1'b0, 4'd0, lat);
        check("t2_lat", 32'(lat), 32'd8);
        check("t2_ack", 32'(c_ack), 32'h02);
        check("t2_pc", 32'(c_pc), 32'h2100);

        // T3: SVC 3 rejected (vector cur 1 < current 4).
        irq = '0; irq_pri = '0; psw_in = 16'h0080; sp_in = 16'h0800;
        snap();
        run(1'b0, 1'b1, 4'd3, lat);
        check("t3_lat", 32'(lat), 32'd2);
        check("t3_fault", 32'(n_fault - b_fault), 32'd1);
        check("t3_nwr", 32'(n_wr - b_wr), 32'd0);
        check("t3_nld", 32'(n_ld - b_ld), 32'd0);
        check("t3_nack", 32'(n_ack - b_ack), 32'd0);

        // T4: plain return, popping the frame T1 pushed (PSW slot given SLP set).
        poke(16'h07FC, 16'h404C);
        psw_in = 16'h0000; sp_in = 16'h07F8;
        snap();
        run(1'b1, 1'b0, 4'd0, lat);
        check("t4_lat", 32'(lat), 32'd5);
        check("t4_cex", 32'(c_cex), 32'h9ABC);
        check("t4_psw", 32'(c_psw), 32'h4044);
        check("t4_lr", 32'(c_lr), 32'h5678);
        check("t4_pc", 32'(c_pc), 32'h1234);
        check("t4_sp", 32'(c_sp), 32'h0800);
        check("t4_nwr", 32'(n_wr - b_wr), 32'd0);
        check("t4_nld", 32'(n_ld - b_ld), 32'd5);

        // T5: tail-chain to source 4 (pri 6 > prev 2).
        irq = 8'h10; irq_pri = '0; irq_pri[12 +: 3] = 3'd6;
        psw_in = 16'h40C0; sp_in = 16'h0700;
        snap();
        run(1'b1, 1'b0, 4'd0, lat);
        check("t5_lat", 32'(lat), 32'd4);
        check("t5_nwr", 32'(n_wr - b_wr), 32'd0);
        check("t5_psw", 32'(c_psw), 32'h40A0);
        check("t5_pc", 32'(c_pc), 32'h3000);
        check("t5_sp", 32'(c_sp), 32'h0700);
        check("t5_ack", 32'(c_ack), 32'h10);

        // T6: 3 wait states, reset during PUSH_LR, then a clean entry.
        ack_dly = 3;
        irq = 8'h04; irq_pri = '0; irq_pri[6 +: 3] = 3'd5;
        psw_in = 16'h0040; sp_in = 16'h0A00;
        snap();
        @(negedge clk);
        svc_inst = 1'b0;
        start_enter = 1'b1;
        @(posedge clk);
        #1;
        start_enter = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (n_wr == b_wr + 1) break;
        end
        check("t6_pre_nwr", 32'(n_wr - b_wr), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ctl", {28'd0, mem_req, mem_we, busy, done}, 32'd0);
        check("t6_rst_bus", {mem_addr, mem_wdata}, 32'd0);
        check("t6_rst_ld", {19'd0, irq_ack, pc_ld, lr_ld, psw_ld, cex_ld, sp_ld}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        check("t6_mem_kept", 32'(mem[16'h0A00 >> 1]), 32'h1234);
        snap();
        run(1'b0, 1'b0, 4'd0, lat);
        check("t6_lat", 32'(lat), 32'd26);
        check_writes("t6", 16'h0A00, 16'h0040);
        check("t6_sp", 32'(c_sp), 32'h09F8);
        check("t6_ack", 32'(c_ack), 32'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
